usart_recv_frame: RTL and testbench

- UART frame receiver; the receiving end of the 5-byte frame link.
- Deserializes 8N1 bytes from `uart_rxd` and assembles the fixed frame: Adress byte, Mod_SEL byte, then D[23:16], D[15:8], D[7:0].
- Presents the decoded fields with a one-cycle valid strobe.
- Sits at the board-side UART input and feeds mode/address/data registers downstream.

---
 rtl/usart_recv_frame.sv | 264 ++++++++++++++++++++++++++
 tb/tb_usart_recv_frame.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/usart_recv_frame.sv
// usart_recv_frame
//   Receiving end of the 5-byte UART frame link. Deserializes 8N1 bytes from uart_rxd and
//   assembles a frame of Adress byte, Mod_SEL byte, then D[23:16], D[15:8], D[7:0]. A complete
//   frame is loaded into the outputs with a one-cycle frame_valid strobe. A framing error or an
//   inter-byte timeout discards the partial frame with a one-cycle frame_err strobe.
//
// Parameters
//   BPS_CNT      clock cycles per bit
//   TIMEOUT_CNT  maximum idle cycles allowed between consecutive bytes of one frame
//
// Ports
//   sys_clk      system clock, rising edge
//   sys_rst      asynchronous active-low reset
//   uart_rxd     serial input, asynchronous to sys_clk, idles high
//   D            frame data, byte 3 in the MSBs
//   Adress       frame byte 1 [1:0]
//   Mod_SEL      frame byte 2 [5:0]
//   frame_valid  one-cycle pulse when a new frame is loaded
//   frame_err    one-cycle pulse when a partial frame is discarded
//
// Configuration
//   USART_RX_HDR_CHECK_EN  when defined, a completed frame whose byte 1 [7:2] or byte 2 [7:6]
//                          is nonzero is discarded with frame_err instead of being loaded.

module usart_recv_frame #(
   parameter logic [15:0] BPS_CNT     = 16'd434,
   parameter logic [15:0] TIMEOUT_CNT = 16'd20000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        uart_rxd,
   output logic [23:0] D,
   output logic [1:0]  Adress,
   output logic [5:0]  Mod_SEL,
   output logic        frame_valid,
   output logic        frame_err
);

   localparam logic [15:0] HalfBps = BPS_CNT / 16'd2;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Synchronizer plus one extra stage for falling-edge detection
   logic rxd_s1_q, rxd_s2_q, rxd_prev_q;
   logic fall;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        byte_done, stop_err;
   logic        byte_done_q, stop_err_q;

   logic [2:0]  idx_q, idx_d;
   logic [1:0]  b0_q, b0_d;
   logic [5:0]  b1_q, b1_d;
   logic [7:0]  b2_q, b2_d;
   logic [7:0]  b3_q, b3_d;
   logic [15:0] tmo_q, tmo_d;
   logic [23:0] d_q, d_d;
   logic [1:0]  adress_q, adress_d;
   logic [5:0]  mod_sel_q, mod_sel_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        hdr_bad;
`ifdef USART_RX_HDR_CHECK_EN
   logic        hdr_bad_q, hdr_bad_d;
`endif

   // A falling edge needs the line to have been high the cycle before, so a line still low
   // after a bad stop bit cannot start a new byte.
   assign fall = rxd_prev_q & ~rxd_s2_q;

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_s1_q   <= uart_rxd;
         rxd_s2_q   <= rxd_s1_q;
         rxd_prev_q <= rxd_s2_q;
      end
   end

   // Bit FSM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      byte_done = 1'b0;
      stop_err  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d     = '0;
            bit_cnt_d = '0;
            if (fall) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == HalfBps) begin
               cnt_d   = '0;
               state_d = rxd_s2_q ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StData: begin
            if (cnt_q == BPS_CNT - 16'd1) begin
               cnt_d     = '0;
               shift_d   = {rxd_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (cnt_q == BPS_CNT - 16'd1) begin
               cnt_d   = '0;
               state_d = StIdle;
               if (rxd_s2_q) begin
                  byte_done = 1'b1;
               end else begin
                  stop_err = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         byte_done_q <= 1'b0;
         stop_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         byte_done_q <= byte_done;
         stop_err_q  <= stop_err;
      end
   end

   // Frame assembler. It acts one cycle after the stop sample; shift_q is stable then because
   // the next byte cannot shift in for at least half a bit.
   always_comb begin
      idx_d     = idx_q;
      b0_d      = b0_q;
      b1_d      = b1_q;
      b2_d      = b2_q;
      b3_d      = b3_q;
      d_d       = d_q;
      adress_d  = adress_q;
      mod_sel_d = mod_sel_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      hdr_bad   = 1'b0;
`ifdef USART_RX_HDR_CHECK_EN
      hdr_bad_d = hdr_bad_q;
      hdr_bad   = hdr_bad_q;
`endif

      // Timeout counter: held at 0 with no partial frame, cleared by any falling edge
      if (idx_q == 3'd0 || fall) begin
         tmo_d = '0;
      end else if (state_q == StIdle && tmo_q != TIMEOUT_CNT) begin
         tmo_d = tmo_q + 16'd1;
      end else begin
         tmo_d = tmo_q;
      end

      if (stop_err_q) begin
         idx_d = '0;
         err_d = 1'b1;
      end else if (byte_done_q) begin
         idx_d = idx_q + 3'd1;
         unique case (idx_q)
            3'd0: begin
               b0_d = shift_q[1:0];
`ifdef USART_RX_HDR_CHECK_EN
               hdr_bad_d = |shift_q[7:2];
`endif
            end
            3'd1: begin
               b1_d = shift_q[5:0];
`ifdef USART_RX_HDR_CHECK_EN
               hdr_bad_d = hdr_bad_q | (|shift_q[7:6]);
`endif
            end
            3'd2: b2_d = shift_q;
            3'd3: b3_d = shift_q;
            default: begin
               idx_d = '0;
               if (hdr_bad) begin
                  err_d = 1'b1;
               end else begin
                  d_d       = {b2_q, b3_q, shift_q};
                  adress_d  = b0_q;
                  mod_sel_d = b1_q;
                  valid_d   = 1'b1;
               end
            end
         endcase
      end else if (idx_q != 3'd0 && !fall && state_q == StIdle && tmo_q == TIMEOUT_CNT) begin
         idx_d = '0;
         tmo_d = '0;
         err_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         idx_q     <= '0;
         b0_q      <= '0;
         b1_q      <= '0;
         b2_q      <= '0;
         b3_q      <= '0;
         tmo_q     <= '0;
         d_q       <= '0;
         adress_q  <= '0;
         mod_sel_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
`ifdef USART_RX_HDR_CHECK_EN
         hdr_bad_q <= 1'b0;
`endif
      end else begin
         idx_q     <= idx_d;
         b0_q      <= b0_d;
         b1_q      <= b1_d;
         b2_q      <= b2_d;
         b3_q      <= b3_d;
         tmo_q     <= tmo_d;
         d_q       <= d_d;
         adress_q  <= adress_d;
         mod_sel_q <= mod_sel_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
`ifdef USART_RX_HDR_CHECK_EN
         hdr_bad_q <= hdr_bad_d;
`endif
      end
   end

   assign D           = d_q;
   assign Adress      = adress_q;
   assign Mod_SEL     = mod_sel_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;

endmodule

// File: tb/tb_usart_recv_frame.sv
module tb_usart_recv_frame;

   localparam logic [15:0] Bps = 16'd16;
   localparam logic [15:0] Tmo = 16'd400;
   localparam int LongIdle = 450;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        uart_rxd = 1'b1;
   logic [23:0] D;
   logic [1:0]  Adress;
   logic [5:0]  Mod_SEL;
   logic        frame_valid;
   logic        frame_err;

   usart_recv_frame #(
      .BPS_CNT    (Bps),
      .TIMEOUT_CNT(Tmo)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .uart_rxd   (uart_rxd),
      .D          (D),
      .Adress     (Adress),
      .Mod_SEL    (Mod_SEL),
      .frame_valid(frame_valid),
      .frame_err  (frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Pulse monitor: counts high cycles, so a stretched pulse shows up as an extra count
   int cyc = 0;
   int valid_hi = 0;
   int err_hi = 0;
   int overlap = 0;
   int last_valid_cyc = -1000;

   always @(negedge sys_clk) begin
      cyc <= cyc + 1;
      if (frame_valid) begin
         valid_hi       <= valid_hi + 1;
         last_valid_cyc <= cyc;
      end
      if (frame_err) err_hi <= err_hi + 1;
      if (frame_valid && frame_err) overlap <= overlap + 1;
   end

   // Reference model: a frame is a list of bytes, indexed by position
   int          m_idx = 0;
   logic [7:0]  m_b [5];
   logic [23:0] m_d = '0;
   logic [1:0]  m_adr = '0;
   logic [5:0]  m_mod = '0;
   int          m_valid = 0;
   int          m_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v);
      uart_rxd = v;
      repeat (int'(Bps)) @(negedge sys_clk);
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(negedge sys_clk);
      if (n > int'(Tmo) + 20 && m_idx != 0) begin
         m_idx = 0;
         m_err++;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      int stop_start;
      logic hdr_bad;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      stop_start = cyc;
      drive_bit(stop);
      if (!stop) begin
         drive_bit(1'b1);
         m_idx = 0;
         m_err++;
      end else begin
         m_b[m_idx] = b;
         if (m_idx == 4) begin
            m_idx = 0;
            hdr_bad = 1'b0;
`ifdef USART_RX_HDR_CHECK_EN
            hdr_bad = (m_b[0] >= 8'd4) || (m_b[1] >= 8'd64);
`endif
            if (hdr_bad) begin
               m_err++;
            end else begin
               m_adr = m_b[0][1:0];
               m_mod = m_b[1][5:0];
               m_d   = {m_b[2], m_b[3], m_b[4]};
               m_valid++;
               // Stop sample lands mid stop bit; the strobe follows within that bit
               chk("valid_timing", 32'((last_valid_cyc - stop_start >= 2) &&
                                       (last_valid_cyc - stop_start <= int'(Bps))), 32'd1);
            end
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic check_all(input string tag);
      repeat (2) @(negedge sys_clk);
      chk({tag, ".D"}, D, m_d);
      chk({tag, ".Adress"}, Adress, m_adr);
      chk({tag, ".Mod_SEL"}, Mod_SEL, m_mod);
      chk({tag, ".valid_cnt"}, valid_hi, m_valid);
      chk({tag, ".err_cnt"}, err_hi, m_err);
   endtask

   initial begin
      int n_bytes;
      int vh, eh;
      logic [7:0] rb;
      logic rs;

      // Reset state
      repeat (4) @(negedge sys_clk);
      chk("rst.D", D, 24'd0);
      chk("rst.Adress", Adress, 2'd0);
      chk("rst.Mod_SEL", Mod_SEL, 6'd0);
      chk("rst.valid", frame_valid, 1'b0);
      chk("rst.err", frame_err, 1'b0);
      sys_rst = 1'b1;
      idle(20);
      check_all("idle");

      // Good frame, back-to-back bytes
      send_byte(8'h02, 1'b1); send_byte(8'h2A, 1'b1); send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1); send_byte(8'h56, 1'b1);
      check_all("good1");

      // Bad stop on byte 3, then bytes 4-5 form a partial frame that times out
      send_byte(8'h03, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h99, 1'b0);
      check_all("ferr");
      send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1);
      idle(LongIdle);
      check_all("ferr_tmo");

      // Two bytes, timeout, then a full frame
      send_byte(8'h01, 1'b1); send_byte(8'h05, 1'b1);
      idle(LongIdle);
      check_all("tmo");
      send_byte(8'h01, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1); send_byte(8'hEF, 1'b1);
      check_all("after_tmo");

      // Short low glitch on an idle line is a false start
      uart_rxd = 1'b0;
      repeat (3) @(negedge sys_clk);
      idle(50);
      check_all("glitch");

      // Upper header bits set
      send_byte(8'h82, 1'b1); send_byte(8'h2A, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
      check_all("hdr");

      // Randomized byte streams with occasional bad stops, gaps and timeouts
      for (int it = 0; it < 12; it++) begin
         n_bytes = $urandom_range(2, 7);
         for (int k = 0; k < n_bytes; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 9) != 0);
            send_byte(rb, rs);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 40));
         end
         if ($urandom_range(0, 3) == 0) idle(LongIdle);
         check_all("rand");
      end
      idle(LongIdle);
      check_all("rand_flush");

      // Reset in the middle of byte 3
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
      drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
      vh = valid_hi;
      eh = err_hi;
      sys_rst  = 1'b0;
      uart_rxd = 1'b1;
      @(negedge sys_clk);
      chk("midrst.D", D, 24'd0);
      chk("midrst.Adress", Adress, 2'd0);
      chk("midrst.Mod_SEL", Mod_SEL, 6'd0);
      repeat (20) @(negedge sys_clk);
      chk("midrst.valid_cnt", valid_hi, vh);
      chk("midrst.err_cnt", err_hi, eh);
      sys_rst = 1'b1;
      m_idx = 0;
      m_d   = '0;
      m_adr = '0;
      m_mod = '0;
      idle(30);
      check_all("post_rst");
      send_byte(8'h03, 1'b1); send_byte(8'h3F, 1'b1); send_byte(8'hDE, 1'b1);
      send_byte(8'hAD, 1'b1); send_byte(8'hBE, 1'b1);
      check_all("post_rst_frame");

      chk("no_overlap", overlap, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
